supernova_wb_arbiter: RTL and testbench
=======================================

Name: supernova_wb_arbiter

Overview:
Writeback-side producer for the physical register file (PRF). It collects results from NUM_SRC execution units over valid/ready handshakes and buffers each source in its own small FIFO. Each cycle it picks up to NUM_WRITE_PORTS results with a rotating round-robin priority. It drives the PRF GPR/FPR write ports from registered outputs.

Parameters:
NUM_SRC, 6, number of producing execution units
NUM_WRITE_PORTS, supernova_pkg::COMMIT_WIDTH (4), write slots per cycle, shared by GPR and FPR
TAG_WIDTH, supernova_pkg::GPR_TAG_WIDTH (7), physical tag width, same for FPR
DATA_WIDTH, stu_pkg::REG_WIDTH (64), result width
FIFO_DEPTH, 2, entries per source FIFO (power of two, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush_in  in  1  pipeline flush; discards all buffered results
src_valid_in  in  NUM_SRC  result offered by source s
src_ready_out  out  NUM_SRC  source s FIFO can accept
src_is_fp_in  in  NUM_SRC  1 = FPR destination, 0 = GPR
src_tag_in  in  NUM_SRC x TAG_WIDTH  destination physical tag
src_data_in  in  NUM_SRC x DATA_WIDTH  result value
gpr_write_valid_out  out  NUM_WRITE_PORTS  GPR write strobe per slot
gpr_write_addr_out  out  NUM_WRITE_PORTS x TAG_WIDTH  GPR tag per slot
gpr_write_data_out  out  NUM_WRITE_PORTS x DATA_WIDTH  GPR data per slot
fpr_write_valid_out  out  NUM_WRITE_PORTS  FPR write strobe per slot
fpr_write_addr_out  out  NUM_WRITE_PORTS x TAG_WIDTH  FPR tag per slot
fpr_write_data_out  out  NUM_WRITE_PORTS x DATA_WIDTH  FPR data per slot

Behaviour:
- Reset (async, rst_n=0): all FIFOs empty, all occupancy counters 0, RR pointer 0, all *_write_valid_out 0, addr/data outputs 0. Because all FIFOs are empty, src_ready_out = all 1 during and after reset.
- Handshake: push on src_valid_in[s] & src_ready_out[s]. src_ready_out[s] = (count[s] < FIFO_DEPTH), taken only from the registered count. There is no same-cycle pop-to-push bypass, so a full FIFO stays not-ready for that cycle even when it is popped.
- Per-source FIFO: circular buffer with wr/rd pointers that wrap modulo FIFO_DEPTH. count increments on push, decrements on pop, and is unchanged on simultaneous push and pop. Order within a source is preserved.
- GPR tag 0 filter: a GPR result with tag 0 is accepted and stored as usual. When popped it uses a slot but drives no write strobe (gpr_write_valid_out stays 0 for that slot).
- Selection, combinational each cycle:
  - Scan sources starting at the RR pointer, in order ptr, ptr+1, ... mod NUM_SRC.
  - The first NUM_WRITE_PORTS non-empty sources are granted, one pop each, into slots 0..k-1 in scan order.
  - A source is popped at most once per cycle.
- Output register: at each edge, for every slot k:
  - granted with is_fp=0: gpr_write_valid_out[k]=1 and gpr addr/data = head entry; fpr_write_valid_out[k]=0.
  - granted with is_fp=1: the mirror case on the FPR port.
  - not granted: both valids 0; addr/data hold their previous values.
  - A slot never asserts both the GPR and FPR valid.
- Latency: push at edge E0 makes the entry eligible in the next cycle. Selection then loads the outputs at edge E1, so write valid is high in the cycle after E1. Minimum latency is 2 edges from src_valid_in sampled to PRF write strobe.
- RR pointer: if at least one grant occurs, the pointer becomes (last granted source + 1) mod NUM_SRC. Otherwise it is unchanged.
- Flush (flush_in=1 at an edge):
  - all counts and pointers cleared, and the same-cycle push and pop are discarded;
  - all write valids 0 next cycle; RR pointer reset to 0.
  - src_ready_out returns to all 1 in the cycle after the flush.
- Duplicate tags: no check is made. Two slots writing the same tag are left to the PRF.
- Reset mid-operation: immediate return to the reset state; buffered results are lost.

Test Plan:
1. Reset, then source 2 pushes {is_fp=0, tag=5, data=0xDEAD} for one cycle -> gpr_write_valid_out=0001, gpr_write_addr_out[0]=5, gpr_write_data_out[0]=0xDEAD exactly 2 edges later; fpr valids 0; one cycle only.
2. All 6 sources push one GPR result each (tags 10..15) in the same cycle, pointer=0 -> the first output cycle writes tags 10,11,12,13 in slots 0..3. The next cycle writes 14,15 in slots 0,1 with valid=0011. The pointer then equals 0.
3. Source 0 pushes on 3 consecutive cycles with no pops possible (FIFO_DEPTH=2), using a bench that holds valid -> src_ready_out[0] drops to 0 after 2 accepts. The 3rd beat is accepted only after a pop, and the output order is preserved (tags 1,2,3).
4. Mixed destinations: source 1 pushes {fp=1, tag=7} and source 3 pushes {fp=0, tag=0} -> slot 0 drives fpr_write_valid_out[0]=1 with addr 7. Slot 1 drives no strobe on either port, and the tag 0 entry is drained.
5. Fill 4 FIFOs and assert flush_in for one cycle -> no write valids in any later cycle, src_ready_out all 1 the cycle after the flush, and the pointer is 0.
6. Fairness: keep all 6 sources continuously non-empty for 6 cycles -> each source granted exactly 4 times, and no source waits more than 2 consecutive cycles.

Source files
------------

// File: rtl/supernova_wb_arbiter_if.sv
// Purpose: execution-unit result handshakes plus PRF GPR/FPR write ports of the writeback arbiter.
// Latency: none; this is wiring only.
// Backpressure: per-source src_ready_out; the PRF write ports cannot stall.
interface supernova_wb_arbiter_if #(
    parameter int NUM_SRC         = 6,
    parameter int NUM_WRITE_PORTS = 4,
    parameter int TAG_WIDTH       = 7,
    parameter int DATA_WIDTH      = 64
);
    logic [NUM_SRC-1:0]                         src_valid_in;
    logic [NUM_SRC-1:0]                         src_ready_out;
    logic [NUM_SRC-1:0]                         src_is_fp_in;
    logic [NUM_SRC-1:0][TAG_WIDTH-1:0]          src_tag_in;
    logic [NUM_SRC-1:0][DATA_WIDTH-1:0]         src_data_in;
    logic [NUM_WRITE_PORTS-1:0]                 gpr_write_valid_out;
    logic [NUM_WRITE_PORTS-1:0][TAG_WIDTH-1:0]  gpr_write_addr_out;
    logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0] gpr_write_data_out;
    logic [NUM_WRITE_PORTS-1:0]                 fpr_write_valid_out;
    logic [NUM_WRITE_PORTS-1:0][TAG_WIDTH-1:0]  fpr_write_addr_out;
    logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0] fpr_write_data_out;

    modport master (
        output src_valid_in, src_is_fp_in, src_tag_in, src_data_in,
        input  src_ready_out,
        input  gpr_write_valid_out, gpr_write_addr_out, gpr_write_data_out,
        input  fpr_write_valid_out, fpr_write_addr_out, fpr_write_data_out
    );

    modport slave (
        input  src_valid_in, src_is_fp_in, src_tag_in, src_data_in,
        output src_ready_out,
        output gpr_write_valid_out, gpr_write_addr_out, gpr_write_data_out,
        output fpr_write_valid_out, fpr_write_addr_out, fpr_write_data_out
    );
endinterface

// File: rtl/supernova_wb_arbiter.sv
// Purpose: buffers NUM_SRC result streams and round-robins up to NUM_WRITE_PORTS of them per cycle onto the PRF ports.
// Latency: 2 edges from an accepted push to the registered write strobe.
// Backpressure: src_ready_out drops while a source FIFO holds FIFO_DEPTH entries, with no pop bypass.
module supernova_wb_arbiter #(
    parameter int NUM_SRC         = 6,
    parameter int NUM_WRITE_PORTS = 4,
    parameter int TAG_WIDTH       = 7,
    parameter int DATA_WIDTH      = 64,
    parameter int FIFO_DEPTH      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_in,
    supernova_wb_arbiter_if.slave wb
);
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int KW = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [SW:0]   NSRC_C    = (SW+1)'(NUM_SRC);
    localparam logic [SW-1:0] LAST_SRC  = SW'(NUM_SRC - 1);
    localparam logic [KW-1:0] LAST_SLOT = KW'(NUM_WRITE_PORTS - 1);

    logic [NUM_SRC-1:0][FIFO_DEPTH-1:0]                 fp_mem;
    logic [NUM_SRC-1:0][FIFO_DEPTH-1:0][TAG_WIDTH-1:0]  tag_mem;
    logic [NUM_SRC-1:0][FIFO_DEPTH-1:0][DATA_WIDTH-1:0] data_mem;
    logic [NUM_SRC-1:0][PW-1:0]                         wr_ptr_q, rd_ptr_q;
    logic [NUM_SRC-1:0][CW-1:0]                         count_q;
    logic [SW-1:0]                                      rr_q, rr_d;

    logic [NUM_SRC-1:0]                  ready, push, pop, head_fp;
    logic [NUM_SRC-1:0][TAG_WIDTH-1:0]   head_tag;
    logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  head_data;
    logic [NUM_WRITE_PORTS-1:0]          slot_vld;
    logic [NUM_WRITE_PORTS-1:0][SW-1:0]  slot_src;

    logic [NUM_WRITE_PORTS-1:0]                 gpr_vld_q, fpr_vld_q;
    logic [NUM_WRITE_PORTS-1:0][TAG_WIDTH-1:0]  gpr_addr_q, fpr_addr_q;
    logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0] gpr_data_q, fpr_data_q;

    // Ready comes from the registered count only, so a full FIFO stays closed even in a pop cycle.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            ready[s]     = (count_q[s] < DEPTH_C);
            head_fp[s]   = fp_mem[s][rd_ptr_q[s]];
            head_tag[s]  = tag_mem[s][rd_ptr_q[s]];
            head_data[s] = data_mem[s][rd_ptr_q[s]];
        end
    end

    assign push             = wb.src_valid_in & ready;
    assign wb.src_ready_out = ready;

    // Scan from rr_q; the first NUM_WRITE_PORTS non-empty sources fill slots in scan order.
    always_comb begin
        logic [SW:0]   sum;
        logic [SW-1:0] idx;
        logic [KW-1:0] n;
        logic          full;
        pop      = '0;
        slot_vld = '0;
        slot_src = '0;
        rr_d     = rr_q;
        sum      = '0;
        idx      = '0;
        n        = '0;
        full     = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sum = {1'b0, rr_q} + (SW+1)'(i);
            if (sum >= NSRC_C) sum = sum - NSRC_C;
            idx = sum[SW-1:0];
            if (!full && (count_q[idx] != '0)) begin
                pop[idx]      = 1'b1;
                slot_vld[n]   = 1'b1;
                slot_src[n]   = idx;
                rr_d          = (idx == LAST_SRC) ? '0 : idx + 1'b1;
                if (n == LAST_SLOT) full = 1'b1;
                else                n    = n + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= '0;
        end else if (flush_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= '0;
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (push[s]) wr_ptr_q[s] <= wr_ptr_q[s] + 1'b1;
                if (pop[s])  rd_ptr_q[s] <= rd_ptr_q[s] + 1'b1;
                if (push[s] && !pop[s])      count_q[s] <= count_q[s] + 1'b1;
                else if (!push[s] && pop[s]) count_q[s] <= count_q[s] - 1'b1;
            end
            rr_q <= rr_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (push[s] && !flush_in) begin
                fp_mem[s][wr_ptr_q[s]]   <= wb.src_is_fp_in[s];
                tag_mem[s][wr_ptr_q[s]]  <= wb.src_tag_in[s];
                data_mem[s][wr_ptr_q[s]] <= wb.src_data_in[s];
            end
        end
    end

    // GPR tag 0 is the hardwired zero register: it consumes a slot but never strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpr_vld_q  <= '0;
            fpr_vld_q  <= '0;
            gpr_addr_q <= '0;
            fpr_addr_q <= '0;
            gpr_data_q <= '0;
            fpr_data_q <= '0;
        end else begin
            for (int k = 0; k < NUM_WRITE_PORTS; k++) begin
                gpr_vld_q[k] <= 1'b0;
                fpr_vld_q[k] <= 1'b0;
                if (!flush_in && slot_vld[k]) begin
                    if (head_fp[slot_src[k]]) begin
                        fpr_vld_q[k]  <= 1'b1;
                        fpr_addr_q[k] <= head_tag[slot_src[k]];
                        fpr_data_q[k] <= head_data[slot_src[k]];
                    end else begin
                        gpr_vld_q[k]  <= (head_tag[slot_src[k]] != '0);
                        gpr_addr_q[k] <= head_tag[slot_src[k]];
                        gpr_data_q[k] <= head_data[slot_src[k]];
                    end
                end
            end
        end
    end

    assign wb.gpr_write_valid_out = gpr_vld_q;
    assign wb.gpr_write_addr_out  = gpr_addr_q;
    assign wb.gpr_write_data_out  = gpr_data_q;
    assign wb.fpr_write_valid_out = fpr_vld_q;
    assign wb.fpr_write_addr_out  = fpr_addr_q;
    assign wb.fpr_write_data_out  = fpr_data_q;
endmodule

// File: tb/tb_supernova_wb_arbiter.sv
// Directed bench for supernova_wb_arbiter: a vector table for steady-state selection,
// plus hand-written sequences for backpressure, flush, fairness and mid-run reset.
module tb_supernova_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    supernova_wb_arbiter_if #(.NUM_SRC(6), .NUM_WRITE_PORTS(4), .TAG_WIDTH(7), .DATA_WIDTH(64)) wb ();

    supernova_wb_arbiter #(
        .NUM_SRC(6), .NUM_WRITE_PORTS(4), .TAG_WIDTH(7), .DATA_WIDTH(64), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush_in(flush), .wb(wb)
    );

    typedef struct {
        string           nm;
        logic            fl;
        logic [5:0]      vld;
        logic [5:0]      fp;
        logic [5:0][6:0] tag;
        logic [3:0]      gv;
        logic [3:0]      fv;
        logic [5:0]      rdy;
        logic [3:0][6:0] ea;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [63:0] mk_data(input logic [6:0] t);
        return {32'hDA7A5EED, 25'd0, t};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb.src_valid_in = '0;
        wb.src_is_fp_in = '0;
        wb.src_tag_in   = '0;
        wb.src_data_in  = '0;
        flush           = 1'b0;
    endtask

    task automatic drive(input int s, input logic fp, input logic [6:0] t);
        wb.src_valid_in[s] = 1'b1;
        wb.src_is_fp_in[s] = fp;
        wb.src_tag_in[s]   = t;
        wb.src_data_in[s]  = mk_data(t);
    endtask

    task automatic set_vec(input int i, input string nm, input logic fl, input logic [5:0] vld,
                           input logic [5:0] fp, input logic [5:0][6:0] tag, input logic [3:0] gv,
                           input logic [3:0] fv, input logic [3:0][6:0] ea);
        tbl[i].nm = nm;  tbl[i].fl = fl;  tbl[i].vld = vld; tbl[i].fp = fp;
        tbl[i].tag = tag; tbl[i].gv = gv; tbl[i].fv = fv;  tbl[i].rdy = 6'h3F;
        tbl[i].ea = ea;
    endtask

    task automatic check_row(input vec_t v);
        logic [3:0][6:0] act_a;
        logic [3:0][6:0] exp_a;
        int              dbad;
        dbad = 0;
        for (int k = 0; k < 4; k++) begin
            act_a[k] = '0;
            exp_a[k] = (v.gv[k] | v.fv[k]) ? v.ea[k] : 7'd0;
            if (v.gv[k]) begin
                act_a[k] = wb.gpr_write_addr_out[k];
                if (wb.gpr_write_data_out[k] !== mk_data(v.ea[k])) dbad++;
            end else if (v.fv[k]) begin
                act_a[k] = wb.fpr_write_addr_out[k];
                if (wb.fpr_write_data_out[k] !== mk_data(v.ea[k])) dbad++;
            end
        end
        chk({v.nm, "_gpr_vld"}, 64'(wb.gpr_write_valid_out), 64'(v.gv));
        chk({v.nm, "_fpr_vld"}, 64'(wb.fpr_write_valid_out), 64'(v.fv));
        chk({v.nm, "_ready"},   64'(wb.src_ready_out),       64'(v.rdy));
        chk({v.nm, "_addr"},    64'(act_a),                  64'(exp_a));
        chk({v.nm, "_data_bad"}, 64'(dbad),                  64'd0);
    endtask

    initial begin
        int gcnt[6];
        int miss[6];
        int maxmiss;
        logic [5:0] gm;

        // Table rows: inputs before the edge, expected outputs just after it.
        set_vec(0,  "t0_flush_idle", 1'b1, 6'h00, 6'h00, '0, 4'h0, 4'h0, '0);
        set_vec(1,  "t1_push6",      1'b0, 6'h3F, 6'h00, {7'd15,7'd14,7'd13,7'd12,7'd11,7'd10}, 4'h0, 4'h0, '0);
        set_vec(2,  "t2_first4",     1'b0, 6'h00, 6'h00, '0, 4'hF, 4'h0, {7'd13,7'd12,7'd11,7'd10});
        set_vec(3,  "t3_last2",      1'b0, 6'h00, 6'h00, '0, 4'h3, 4'h0, {7'd0,7'd0,7'd15,7'd14});
        set_vec(4,  "t4_push6b",     1'b0, 6'h3F, 6'h00, {7'd25,7'd24,7'd23,7'd22,7'd21,7'd20}, 4'h0, 4'h0, '0);
        set_vec(5,  "t5_ptr0_first", 1'b0, 6'h00, 6'h00, '0, 4'hF, 4'h0, {7'd23,7'd22,7'd21,7'd20});
        set_vec(6,  "t6_ptr0_last",  1'b0, 6'h00, 6'h00, '0, 4'h3, 4'h0, {7'd0,7'd0,7'd25,7'd24});
        set_vec(7,  "t7_mixed_push", 1'b0, 6'h0A, 6'h02, {7'd0,7'd0,7'd0,7'd0,7'd7,7'd0}, 4'h0, 4'h0, '0);
        set_vec(8,  "t8_fp_tag0",    1'b0, 6'h00, 6'h00, '0, 4'h0, 4'h1, {7'd0,7'd0,7'd0,7'd7});
        set_vec(9,  "t9_tag0_gone",  1'b0, 6'h00, 6'h00, '0, 4'h0, 4'h0, '0);
        set_vec(10, "t10_push_mix",  1'b0, 6'h3F, 6'h21, {7'd35,7'd34,7'd33,7'd32,7'd31,7'd30}, 4'h0, 4'h0, '0);
        set_vec(11, "t11_wrap4",     1'b0, 6'h00, 6'h00, '0, 4'h9, 4'h6, {7'd31,7'd30,7'd35,7'd34});
        set_vec(12, "t12_wrap_rest", 1'b0, 6'h00, 6'h00, '0, 4'h3, 4'h0, {7'd0,7'd0,7'd33,7'd32});

        // Reset state
        idle();
        rst_n = 1'b0;
        #12;
        chk("rst_ready",    64'(wb.src_ready_out),       64'h3F);
        chk("rst_gpr_vld",  64'(wb.gpr_write_valid_out), 64'h0);
        chk("rst_fpr_vld",  64'(wb.fpr_write_valid_out), 64'h0);
        chk("rst_gpr_addr", 64'(wb.gpr_write_addr_out),  64'h0);
        chk("rst_fpr_data", 64'(wb.fpr_write_data_out[0]), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 64'(wb.src_ready_out), 64'h3F);

        // Single push: strobe exactly two edges later, for one cycle
        drive(2, 1'b0, 7'd5);
        wb.src_data_in[2] = 64'hDEAD;
        step();
        chk("s1_e0_vld", 64'(wb.gpr_write_valid_out), 64'h0);
        idle();
        step();
        chk("s1_e1_vld",  64'(wb.gpr_write_valid_out), 64'h1);
        chk("s1_e1_addr", 64'(wb.gpr_write_addr_out[0]), 64'd5);
        chk("s1_e1_data", wb.gpr_write_data_out[0], 64'hDEAD);
        chk("s1_e1_fpr",  64'(wb.fpr_write_valid_out), 64'h0);
        step();
        chk("s1_e2_vld", 64'(wb.gpr_write_valid_out), 64'h0);

        for (int i = 0; i < 13; i++) begin
            flush             = tbl[i].fl;
            wb.src_valid_in   = tbl[i].vld;
            wb.src_is_fp_in   = tbl[i].fp;
            wb.src_tag_in     = tbl[i].tag;
            for (int s = 0; s < 6; s++) wb.src_data_in[s] = mk_data(tbl[i].tag[s]);
            step();
            check_row(tbl[i]);
        end
        idle();

        // Backpressure on source 0 while sources 2..5 (ptr=2) take every slot
        flush = 1'b1;
        step();
        idle();
        drive(1, 1'b0, 7'd40);
        step();
        idle();
        step();
        chk("bp_setup_vld",  64'(wb.gpr_write_valid_out), 64'h1);
        chk("bp_setup_addr", 64'(wb.gpr_write_addr_out[0]), 64'd40);
        drive(0, 1'b0, 7'd1);
        for (int s = 2; s < 6; s++) drive(s, 1'b0, 7'(48 + s));
        step();
        chk("bp_c0_ready", 64'(wb.src_ready_out), 64'h3F);
        drive(0, 1'b0, 7'd2);
        for (int s = 2; s < 6; s++) drive(s, 1'b0, 7'(52 + s));
        step();
        chk("bp_c1_ready", 64'(wb.src_ready_out), 64'h3E);
        chk("bp_c1_vld",   64'(wb.gpr_write_valid_out), 64'hF);
        chk("bp_c1_addr",  64'(wb.gpr_write_addr_out), 64'({7'd53, 7'd52, 7'd51, 7'd50}));
        idle();
        drive(0, 1'b0, 7'd3);
        step();
        chk("bp_c2_ready", 64'(wb.src_ready_out), 64'h3F);
        chk("bp_c2_vld",   64'(wb.gpr_write_valid_out), 64'hF);
        chk("bp_c2_addr",  64'(wb.gpr_write_addr_out), 64'({7'd56, 7'd55, 7'd54, 7'd1}));
        step();
        chk("bp_c3_ready", 64'(wb.src_ready_out), 64'h3F);
        chk("bp_c3_vld",   64'(wb.gpr_write_valid_out), 64'h3);
        chk("bp_c3_addr",  64'(wb.gpr_write_addr_out), 64'({7'd56, 7'd55, 7'd2, 7'd57}));
        idle();
        step();
        chk("bp_c4_vld",   64'(wb.gpr_write_valid_out), 64'h1);
        chk("bp_c4_addr",  64'(wb.gpr_write_addr_out), 64'({7'd56, 7'd55, 7'd2, 7'd3}));
        step();
        chk("bp_c5_vld",   64'(wb.gpr_write_valid_out), 64'h0);

        // Flush with four FIFOs occupied
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 7'(60 + s));
        step();
        for (int s = 0; s < 4; s++) drive(s, 1'b0, 7'(64 + s));
        flush = 1'b1;
        step();
        chk("fl_vld",   64'({wb.gpr_write_valid_out, wb.fpr_write_valid_out}), 64'h0);
        chk("fl_ready", 64'(wb.src_ready_out), 64'h3F);
        idle();
        for (int c = 0; c < 3; c++) begin
            step();
            chk("fl_after_vld", 64'({wb.gpr_write_valid_out, wb.fpr_write_valid_out}), 64'h0);
        end
        for (int s = 0; s < 6; s++) drive(s, 1'b0, 7'(70 + s));
        step();
        idle();
        step();
        chk("fl_ptr0_vld",  64'(wb.gpr_write_valid_out), 64'hF);
        chk("fl_ptr0_addr", 64'(wb.gpr_write_addr_out), 64'({7'd73, 7'd72, 7'd71, 7'd70}));
        step();
        chk("fl_rest_vld",  64'(wb.gpr_write_valid_out), 64'h3);
        chk("fl_rest_addr", 64'({wb.gpr_write_addr_out[1], wb.gpr_write_addr_out[0]}), 64'({7'd75, 7'd74}));

        // Fairness: every source held valid, tags encode the source in bits [6:4]
        for (int s = 0; s < 6; s++) begin
            drive(s, 1'b0, 7'(s * 16 + 1));
            gcnt[s] = 0;
            miss[s] = 0;
        end
        maxmiss = 0;
        step();
        for (int c = 0; c < 6; c++) begin
            step();
            chk("fair_all_slots", 64'(wb.gpr_write_valid_out), 64'hF);
            gm = '0;
            for (int k = 0; k < 4; k++)
                if (wb.gpr_write_valid_out[k] && wb.gpr_write_addr_out[k][6:4] < 3'd6)
                    gm[wb.gpr_write_addr_out[k][6:4]] = 1'b1;
            for (int s = 0; s < 6; s++) begin
                if (gm[s]) begin
                    gcnt[s]++;
                    miss[s] = 0;
                end else begin
                    miss[s]++;
                    if (miss[s] > maxmiss) maxmiss = miss[s];
                end
            end
        end
        for (int s = 0; s < 6; s++) chk("fair_grants", 64'(gcnt[s]), 64'd4);
        chk("fair_max_wait_le2", 64'(maxmiss <= 2), 64'd1);
        idle();
        flush = 1'b1;
        step();
        idle();
        step();

        // Asynchronous reset in the middle of a drain
        for (int s = 0; s < 6; s++) drive(s, 1'b0, 7'(90 + s));
        step();
        idle();
        step();
        chk("mr_pre_vld", 64'(wb.gpr_write_valid_out), 64'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_async_vld",   64'(wb.gpr_write_valid_out), 64'h0);
        chk("mr_async_addr",  64'(wb.gpr_write_addr_out), 64'h0);
        chk("mr_async_ready", 64'(wb.src_ready_out), 64'h3F);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            chk("mr_lost_vld", 64'({wb.gpr_write_valid_out, wb.fpr_write_valid_out}), 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
